// File: rtl/spram_bist_pkg.sv
// Shared definitions for the single-port RAM March BIST controller.
//  - FSM state encoding (IDLE..DONE) as fixed-width constants plus a state typedef
//  - address-counter direction constants
//  - error counter width
package spram_bist_pkg;

    localparam int ERR_W = 8;

    typedef logic [2:0] bist_state_t;

    localparam bist_state_t ST_IDLE  = 3'd0;
    localparam bist_state_t ST_W_UP  = 3'd1;
    localparam bist_state_t ST_RW_UP = 3'd2;
    localparam bist_state_t ST_RW_DN = 3'd3;
    localparam bist_state_t ST_R_UP  = 3'd4;
    localparam bist_state_t ST_DRAIN = 3'd5;
    localparam bist_state_t ST_DONE  = 3'd6;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/spram_bist_cmp_pipe.sv
// Read-compare pipeline for the SPRAM BIST.
// Each cycle one {valid, expected[, address]} entry is pushed; entries reach the
// tail RD_LAT cycles later, aligned with the RAM read data. A valid tail entry whose
// expected word differs from the read data bumps a saturating error counter.
// Optional build macro: SPRAM_BIST_FAIL_LOG_EN adds first-failure address/expected/actual.
// Ports:
//  clk, rst_n     clock, async active-low reset
//  clr_i          synchronous clear of counter, log and pipe (accepted start)
//  issue_i        this cycle is a RAM read
//  exp_i          expected data for this read
//  addr_i         address of this read (fail-log build only)
//  rd_data_i      RAM read data
//  err_count_o    saturating mismatch count
//  fail_*_o       first-mismatch log (fail-log build only)
module spram_bist_cmp_pipe
    import spram_bist_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              issue_i,
    input  logic [DATA_W-1:0] exp_i,
`ifdef SPRAM_BIST_FAIL_LOG_EN
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_exp_o,
    output logic [DATA_W-1:0] fail_act_o,
`endif
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [ERR_W-1:0]  err_count_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] exp_q [RD_LAT];
    logic [ERR_W-1:0]  err_q;
    logic              mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) exp_q[i] <= '0;
        end else if (clr_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue_i;
            exp_q[0] <= exp_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
            end
        end
    end

    assign mismatch = vld_q[RD_LAT-1] && (rd_data_i != exp_q[RD_LAT-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (clr_i) begin
            err_q <= '0;
        end else if (mismatch && (err_q != {ERR_W{1'b1}})) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign err_count_o = err_q;

`ifdef SPRAM_BIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] addr_q [RD_LAT];
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_exp_q;
    logic [DATA_W-1:0] fail_act_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
        end else begin
            addr_q[0] <= addr_i;
            for (int i = 1; i < RD_LAT; i++) addr_q[i] <= addr_q[i-1];
        end
    end

    // Counter still at zero identifies the first mismatch of the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else if (clr_i) begin
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else if (mismatch && (err_q == '0)) begin
            fail_addr_q <= addr_q[RD_LAT-1];
            fail_exp_q  <= exp_q[RD_LAT-1];
            fail_act_q  <= rd_data_i;
        end
    end

    assign fail_addr_o = fail_addr_q;
    assign fail_exp_o  = fail_exp_q;
    assign fail_act_o  = fail_act_q;
`endif

endmodule

// File: rtl/spram_bist_ctrl.sv
// March-style BIST sequencer driving a single-port RAM.
// One accepted start pulse runs W_UP (write BG), RW_UP (read BG / write ~BG),
// RW_DN (read ~BG / write BG), R_UP (read BG), then DRAIN for RD_LAT cycles.
// Optional build macro: SPRAM_BIST_FAIL_LOG_EN adds fail_addr/fail_exp/fail_act outputs.
// Ports:
//  clk, rst_n         clock, async active-low reset
//  start              run request, honoured only when not busy
//  mem_addr/mem_write_enable/mem_write_data   RAM command pins (registered)
//  mem_read_data      RAM read data, valid RD_LAT cycles after a read address
//  busy/done/pass     run status; pass valid while done
//  err_count          saturating mismatch count
//
// state    | meaning
// IDLE     | waiting for start after reset
// W_UP     | background write, ascending
// RW_UP    | read BG then write ~BG per address, ascending
// RW_DN    | read ~BG then write BG per address, descending
// R_UP     | final read of BG, ascending
// DRAIN    | RD_LAT cycles for the last read to reach the comparator
// DONE     | result held until the next start
module spram_bist_ctrl
    import spram_bist_pkg::*;
#(
    parameter int                ADDR_W     = 11,
    parameter int                DATA_W     = 8,
    parameter int                RD_LAT     = 1,
    parameter logic [DATA_W-1:0] BG_PATTERN = 8'h55
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
`ifdef SPRAM_BIST_FAIL_LOG_EN
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
`endif
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
    localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
    localparam logic [2:0]        DRAIN_LOAD = 3'(RD_LAT - 1);

    bist_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_step;
    logic              wr_q, wr_d;
    logic [2:0]        drain_q, drain_d;
    logic              wen_q, wen_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              dir;
    logic              at_term;
    logic              clr;
    logic              in_rw_d;

    always_comb begin
        dir       = (state_q == ST_RW_DN) ? DIR_DN : DIR_UP;
        at_term   = (dir == DIR_UP) ? (addr_q == ADDR_LAST) : (addr_q == ADDR_FIRST);
        addr_step = (dir == DIR_UP) ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = 1'b0;
        drain_d = drain_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_W_UP;
                    addr_d  = ADDR_FIRST;
                    clr     = 1'b1;
                end
            end
            ST_W_UP: begin
                if (at_term) begin
                    state_d = ST_RW_UP;
                    addr_d  = ADDR_FIRST;
                end else begin
                    addr_d = addr_step;
                end
            end
            ST_RW_UP, ST_RW_DN: begin
                // Read half stays on the address; write half advances it.
                if (!wr_q) begin
                    wr_d = 1'b1;
                end else if (at_term) begin
                    if (state_q == ST_RW_UP) begin
                        state_d = ST_RW_DN;
                        addr_d  = ADDR_LAST;
                    end else begin
                        state_d = ST_R_UP;
                        addr_d  = ADDR_FIRST;
                    end
                end else begin
                    addr_d = addr_step;
                end
            end
            ST_R_UP: begin
                if (at_term) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    addr_d = addr_step;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 3'd0) state_d = ST_DONE;
                else                 drain_d = drain_q - 3'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM pins are decoded from next state and registered so they never glitch.
    always_comb begin
        in_rw_d = (state_d == ST_RW_UP) || (state_d == ST_RW_DN);
        wen_d   = (state_d == ST_W_UP) || (in_rw_d && wr_d);
        rd_d    = (state_d == ST_R_UP) || (in_rw_d && !wr_d);
        wdata_d = '0;
        exp_d   = '0;
        case (state_d)
            ST_W_UP:  wdata_d = BG_PATTERN;
            ST_RW_UP: begin
                exp_d = BG_PATTERN;
                if (wr_d) wdata_d = ~BG_PATTERN;
            end
            ST_RW_DN: begin
                exp_d = ~BG_PATTERN;
                if (wr_d) wdata_d = BG_PATTERN;
            end
            ST_R_UP:  exp_d = BG_PATTERN;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            drain_q <= '0;
            wen_q   <= 1'b0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            drain_q <= drain_d;
            wen_q   <= wen_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            exp_q   <= exp_d;
        end
    end

    assign mem_addr         = addr_q;
    assign mem_write_enable = wen_q;
    assign mem_write_data   = wdata_q;
    assign busy             = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done             = (state_q == ST_DONE);
    assign pass             = done && (err_count == '0);

    spram_bist_cmp_pipe #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_cmp_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .issue_i     (rd_q),
        .exp_i       (exp_q),
`ifdef SPRAM_BIST_FAIL_LOG_EN
        .addr_i      (addr_q),
        .fail_addr_o (fail_addr),
        .fail_exp_o  (fail_exp),
        .fail_act_o  (fail_act),
`endif
        .rd_data_i   (mem_read_data),
        .err_count_o (err_count)
    );

endmodule

// File: tb/tb_spram_bist_ctrl.sv
// Bench for spram_bist_ctrl: behavioural RAM (RD_LAT=1) with injectable faults and a
// March reference model that replays the four phases over an array of cells.
module tb_spram_bist_ctrl;

    localparam int          N        = 2048;
    localparam logic [7:0]  BG       = 8'h55;
    localparam int          RUN_BUSY = 6 * N + 1;
    localparam int          IGN_ADDR = 'h400;
    localparam int          F_NONE   = 0;
    localparam int          F_STUCK  = 1;
    localparam int          F_IGNORE = 2;
    localparam int          F_ZERO   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [10:0] mem_addr;
    logic        mem_write_enable;
    logic [7:0]  mem_write_data;
    logic [7:0]  mem_read_data = 8'h00;
    logic        busy, done, pass;
    logic [7:0]  err_count;
`ifdef SPRAM_BIST_FAIL_LOG_EN
    logic [10:0] fail_addr;
    logic [7:0]  fail_exp, fail_act;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spram_bist_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
`ifdef SPRAM_BIST_FAIL_LOG_EN
        .fail_addr        (fail_addr),
        .fail_exp         (fail_exp),
        .fail_act         (fail_act),
`endif
        .err_count        (err_count)
    );

    // ---------------- behavioural RAM with fault injection ----------------
    logic [7:0] mem      [N];
    logic [7:0] init_mem [N];
    logic       load_req = 1'b0;
    int         fmode = F_NONE;
    int         faddr = 0;
    int         fbit  = 0;
    logic       fpol  = 1'b0;

    function automatic logic [7:0] cell_store(int a, logic [7:0] w, logic [7:0] old);
        logic [7:0] v;
        v = w;
        if (fmode == F_IGNORE && a == IGN_ADDR) v = old;
        else if (fmode == F_STUCK && a == faddr) v[fbit] = fpol;
        return v;
    endfunction

    function automatic logic [7:0] cell_read(int a, logic [7:0] s);
        logic [7:0] v;
        v = s;
        if (fmode == F_ZERO) v = 8'h00;
        else if (fmode == F_STUCK && a == faddr) v[fbit] = fpol;
        return v;
    endfunction

    always @(posedge clk) begin
        if (load_req) begin
            for (int a = 0; a < N; a++) mem[a] = init_mem[a];
        end else if (mem_write_enable) begin
            mem[mem_addr] = cell_store(int'(mem_addr), mem_write_data, mem[mem_addr]);
        end
        mem_read_data <= cell_read(int'(mem_addr), mem[mem_addr]);
    end

    // ---------------- reference model: the March test over abstract cells ----------------
    int         m_errs;
    int         m_faddr;
    logic [7:0] m_fexp, m_fact;

    function automatic void model_march();
        logic [7:0] m [N];
        logic [7:0] r, expv;
        int raw, a;
        bit seen;
        raw = 0;
        seen = 0;
        m_faddr = 0; m_fexp = 8'h00; m_fact = 8'h00;
        for (int k = 0; k < N; k++) m[k] = init_mem[k];
        for (int k = 0; k < N; k++) m[k] = cell_store(k, BG, m[k]);
        // phase 1: ascending read BG / write ~BG; 2: descending read ~BG / write BG; 3: ascending read BG
        for (int ph = 1; ph <= 3; ph++) begin
            for (int k = 0; k < N; k++) begin
                a = (ph == 2) ? (N - 1 - k) : k;
                expv = (ph == 2) ? ~BG : BG;
                r = cell_read(a, m[a]);
                if (r != expv) begin
                    if (!seen) begin
                        seen = 1; m_faddr = a; m_fexp = expv; m_fact = r;
                    end
                    raw++;
                end
                if (ph == 1) m[a] = cell_store(a, ~BG, m[a]);
                if (ph == 2) m[a] = cell_store(a, BG, m[a]);
            end
        end
        m_errs = (raw > 255) ? 255 : raw;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic setup_ram(input int mode, input int fa, input int fb, input logic fp);
        fmode = mode; faddr = fa; fbit = fb; fpol = fp;
        for (int a = 0; a < N; a++) init_mem[a] = 8'($urandom);
        if (mode == F_IGNORE) init_mem[IGN_ADDR] = 8'h00;
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
        model_march();
    endtask

    int r_busy, r_wup_bad, r_rd_bad;

    task automatic run_bist(input int pulse_at);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        r_busy = 0; r_wup_bad = 0; r_rd_bad = 0;
        while (busy === 1'b1 && r_busy < 20000) begin
            if (r_busy < N) begin
                if (!(mem_write_enable === 1'b1 && mem_addr === 11'(r_busy) && mem_write_data === BG))
                    r_wup_bad++;
            end
            if (mem_write_enable === 1'b0 && mem_write_data !== 8'h00) r_rd_bad++;
            start = (r_busy == pulse_at);
            @(negedge clk);
            r_busy++;
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, done, pass, mem_write_enable} !== 4'b0000 || err_count !== 8'h00 ||
            mem_addr !== 11'h000 || mem_write_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b pass=%b wen=%b err=%h addr=%h wdata=%h required all zero",
                     busy, done, pass, mem_write_enable, err_count, mem_addr, mem_write_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_test();
        int wait_cyc;
        setup_ram(F_NONE, 0, 0, 1'b0);
        wait_cyc = N + $urandom_range(2, 4000);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (wait_cyc) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy_before_reset: busy=%b required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write_enable !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_immediate: wen=%b busy=%b required 0 0", mem_write_enable, busy);
        end
        checks++;
        if (done !== 1'b0 || err_count !== 8'h00 || mem_addr !== 11'h000) begin
            failures++;
            $display("FAIL mid_reset_state: done=%b err=%h addr=%h required 0 00 000", done, err_count, mem_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fault_free();
        setup_ram(F_NONE, 0, 0, 1'b0);
        run_bist(-1);
        checks++;
        if (r_busy !== RUN_BUSY) begin
            failures++;
            $display("FAIL clean_busy_cycles: got %0d required %0d", r_busy, RUN_BUSY);
        end
        checks++;
        if (r_wup_bad !== 0) begin
            failures++;
            $display("FAIL clean_w_up_writes: %0d bad cycles required 0", r_wup_bad);
        end
        checks++;
        if (r_rd_bad !== 0) begin
            failures++;
            $display("FAIL clean_read_wdata_zero: %0d bad cycles required 0", r_rd_bad);
        end
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'h00) begin
            failures++;
            $display("FAIL clean_result: done=%b pass=%b err=%h required 1 1 00", done, pass, err_count);
        end
        checks++;
        if (mem_write_enable !== 1'b0 || mem_write_data !== 8'h00 || mem_addr !== 11'h7FF) begin
            failures++;
            $display("FAIL clean_idle_pins: wen=%b wdata=%h addr=%h required 0 00 7ff",
                     mem_write_enable, mem_write_data, mem_addr);
        end
    endtask

    task automatic test_stuck_bit();
        setup_ram(F_STUCK, 'h008, 0, 1'b1);
        run_bist(-1);
        checks++;
        if (done !== 1'b1 || err_count !== 8'(m_errs) || pass !== (m_errs == 0)) begin
            failures++;
            $display("FAIL stuck_bit0_hi: done=%b pass=%b err=%0d required done=1 pass=%0d err=%0d",
                     done, pass, err_count, (m_errs == 0), m_errs);
        end
    endtask

    task automatic test_write_ignored();
        setup_ram(F_IGNORE, 0, 0, 1'b0);
        run_bist(-1);
        checks++;
        if (err_count !== 8'd3 || err_count !== 8'(m_errs) || pass !== 1'b0) begin
            failures++;
            $display("FAIL write_ignored: err=%0d pass=%b required err=3 (model %0d) pass=0",
                     err_count, pass, m_errs);
        end
`ifdef SPRAM_BIST_FAIL_LOG_EN
        checks++;
        if (fail_addr !== 11'h400 || fail_exp !== 8'h55 || fail_act !== 8'h00) begin
            failures++;
            $display("FAIL write_ignored_log: addr=%h exp=%h act=%h required 400 55 00",
                     fail_addr, fail_exp, fail_act);
        end
`endif
    endtask

    task automatic test_all_zero();
        setup_ram(F_ZERO, 0, 0, 1'b0);
        run_bist(-1);
        checks++;
        if (err_count !== 8'hFF || pass !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL all_zero_saturate: err=%h pass=%b done=%b required ff 0 1", err_count, pass, done);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b1 || err_count !== 8'hFF) begin
            failures++;
            $display("FAIL done_hold: done=%b err=%h required 1 ff", done, err_count);
        end
    endtask

    task automatic test_back_to_back_busy_start();
        int fa, fb;
        logic fp;
        fa = $urandom_range(0, N - 1);
        fb = $urandom_range(0, 7);
        fp = 1'($urandom);
        setup_ram(F_STUCK, fa, fb, fp);
        run_bist(100);
        checks++;
        if (r_busy !== RUN_BUSY) begin
            failures++;
            $display("FAIL busy_start_ignored: busy cycles %0d required %0d", r_busy, RUN_BUSY);
        end
        checks++;
        if (err_count !== 8'(m_errs) || pass !== (m_errs == 0) || done !== 1'b1) begin
            failures++;
            $display("FAIL random_stuck a=%0d b=%0d p=%b: err=%0d pass=%b required err=%0d pass=%0d",
                     fa, fb, fp, err_count, pass, m_errs, (m_errs == 0));
        end
`ifdef SPRAM_BIST_FAIL_LOG_EN
        checks++;
        if (fail_addr !== 11'(m_faddr) || fail_exp !== m_fexp || fail_act !== m_fact) begin
            failures++;
            $display("FAIL random_stuck_log: addr=%h exp=%h act=%h required %h %h %h",
                     fail_addr, fail_exp, fail_act, 11'(m_faddr), m_fexp, m_fact);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_reset_mid_test();
        test_fault_free();
        test_stuck_bit();
        test_write_ignored();
        test_all_zero();
        test_back_to_back_busy_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
